// File: rtl/timer_pkg.sv
// Shared types, default sizes and the FIFO pointer-width helper for the
// multi-channel capture/alarm timer.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_e;

  localparam int DEF_TIMER_BITWIDTH    = 32;
  localparam int DEF_NB_INSTANCES      = 10;
  localparam int DEF_CAPTURE_DEPTH     = 4;
  localparam int DEF_PRESCALE_BITWIDTH = 8;

  // Address bits needed to index a power-of-two FIFO; pointers carry one more.
  function automatic int fifo_ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Per-channel capture FIFO: registered write, no fall-through, head reads 0
// when empty. Flush beats push and pop; push into a full FIFO succeeds only
// when a pop frees the slot in the same cycle.
module capture_fifo
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_TIMER_BITWIDTH,
  parameter int DEPTH = DEF_CAPTURE_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int AW = fifo_ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign dout    = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are meaningful, and dout masks the array while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/multi_timer_capture.sv
// Multi-channel capture/alarm timer. Define MULTI_TIMER_PRESCALE_EN to build
// the per-channel prescaler; otherwise every RUN cycle is a tick.
module multi_timer_capture
  import timer_pkg::*;
#(
  parameter int TIMER_BITWIDTH    = DEF_TIMER_BITWIDTH,
  parameter int NB_INSTANCES      = DEF_NB_INSTANCES,
  parameter int CAPTURE_DEPTH     = DEF_CAPTURE_DEPTH,
  parameter int PRESCALE_BITWIDTH = DEF_PRESCALE_BITWIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NB_INSTANCES-1:0]                start,
  input  logic [NB_INSTANCES-1:0]                capture,
  input  logic [NB_INSTANCES-1:0]                rst_capture,
  input  logic [NB_INSTANCES*PRESCALE_BITWIDTH-1:0] prescale,
  input  logic [NB_INSTANCES*TIMER_BITWIDTH-1:0] alarm,
  input  logic [NB_INSTANCES-1:0]                alarm_en,
  input  logic [NB_INSTANCES-1:0]                alarm_periodic,
  input  logic [NB_INSTANCES-1:0]                captured_ready,
  output logic [NB_INSTANCES*TIMER_BITWIDTH-1:0] counter,
  output logic [NB_INSTANCES*TIMER_BITWIDTH-1:0] captured,
  output logic [NB_INSTANCES-1:0]                captured_valid,
  output logic [NB_INSTANCES-1:0]                capture_overflow,
  output logic [NB_INSTANCES-1:0]                alarm_out
);

  localparam int W = TIMER_BITWIDTH;
  localparam int P = PRESCALE_BITWIDTH;

  logic [NB_INSTANCES-1:0] start_r;
  logic [NB_INSTANCES-1:0] capture_r;
  logic [NB_INSTANCES-1:0] rst_capture_r;
  logic [NB_INSTANCES-1:0] alarm_en_r;

  // Cleared in reset so an input held high across release reads as a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_r       <= '0;
      capture_r     <= '0;
      rst_capture_r <= '0;
      alarm_en_r    <= '0;
    end else begin
      start_r       <= start;
      capture_r     <= capture;
      rst_capture_r <= rst_capture;
      alarm_en_r    <= alarm_en;
    end
  end

`ifndef MULTI_TIMER_PRESCALE_EN
  logic prescale_unused;
  assign prescale_unused = ^prescale;
`endif

  for (genvar i = 0; i < NB_INSTANCES; i++) begin : g_ch
    timer_state_e state_q;
    timer_state_e state_d;
    logic [W-1:0] cnt_q;
    logic [W-1:0] head;
    logic         armed_q;
    logic         alarm_q;
    logic         ovf_q;
    logic         start_rise;
    logic         capture_rise;
    logic         flush_rise;
    logic         en_rise;
    logic         tick;
    logic         match;
    logic         push;
    logic         pop;
    logic         full;
    logic         valid;

    assign start_rise   = start[i]       & ~start_r[i];
    assign capture_rise = capture[i]     & ~capture_r[i];
    assign flush_rise   = rst_capture[i] & ~rst_capture_r[i];
    assign en_rise      = alarm_en[i]    & ~alarm_en_r[i];

`ifdef MULTI_TIMER_PRESCALE_EN
    logic [P-1:0] psc_q;

    assign tick = (state_q == RUN) && (psc_q == prescale[i*P +: P]);

    always_ff @(posedge clk) begin
      if (rst || start_rise) psc_q <= '0;
      else if (state_q == RUN) psc_q <= tick ? '0 : psc_q + 1'b1;
    end
`else
    assign tick = (state_q == RUN);
`endif

    always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
      state_d = state_q;
      if (start_rise) state_d = RUN;
    end

    assign match = tick & alarm_en[i] & armed_q & (cnt_q == alarm[i*W +: W]);

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q   <= '0;
        armed_q <= 1'b0;
        alarm_q <= 1'b0;
      end else begin
        alarm_q <= match;
        if (start_rise) begin
          cnt_q   <= '0;
          armed_q <= 1'b1;
        end else begin
          if (tick) cnt_q <= (match && alarm_periodic[i]) ? '0 : cnt_q + 1'b1;
          if (en_rise)                          armed_q <= 1'b1;
          else if (match && !alarm_periodic[i]) armed_q <= 1'b0;
        end
      end
    end

    // The pushed word is the pre-update counter, which is also the matched value.
    assign push = capture_rise & (state_q == RUN) & ~start_rise;
    assign pop  = valid & captured_ready[i];

    always_ff @(posedge clk) begin
      if (rst || flush_rise)       ovf_q <= 1'b0;
      else if (push && full && !pop) ovf_q <= 1'b1;
    end

    capture_fifo #(
      .WIDTH(W),
      .DEPTH(CAPTURE_DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (push),
      .data_in(cnt_q),
      .pop    (pop),
      .flush  (flush_rise),
      .dout   (head),
      .valid  (valid),
      .full   (full)
    );

    assign counter[i*W +: W]   = cnt_q;
    assign captured[i*W +: W]  = head;
    assign captured_valid[i]   = valid;
    assign capture_overflow[i] = ovf_q;
    assign alarm_out[i]        = alarm_q;
  end

endmodule

// File: doc/multi_timer_capture.md
Name: multi_timer_capture

Overview:
Next-generation multi-channel capture/alarm timer, the successor of the single-mode timer.
- Adds per-channel prescaler, periodic/one-shot alarm mode, and a capture FIFO with ready/valid pop and overflow flag.
- Sits on the main clock domain; all channels are independent except for the shared clk/rst.

Parameters:
TIMER_BITWIDTH, 32, width of each counter, alarm and captured word
NB_INSTANCES, 10, number of independent timer channels
CAPTURE_DEPTH, 4, capture FIFO entries per channel (power of 2, >=2)
PRESCALE_BITWIDTH, 8, width of each per-channel prescale value

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  NB_INSTANCES  per-channel start; rising edge (re)starts the counter
capture  in  NB_INSTANCES  rising edge pushes the current counter into the FIFO
rst_capture  in  NB_INSTANCES  rising edge flushes the FIFO and clears overflow
prescale  in  NB_INSTANCES*PRESCALE_BITWIDTH  channel i at [i*P +: P]; tick every prescale+1 cycles
alarm  in  NB_INSTANCES*TIMER_BITWIDTH  per-channel compare value
alarm_en  in  NB_INSTANCES  alarm compare enable
alarm_periodic  in  NB_INSTANCES  1 = periodic reload on match, 0 = one-shot
captured_ready  in  NB_INSTANCES  consumer pops the FIFO head
counter  out  NB_INSTANCES*TIMER_BITWIDTH  live counter values
captured  out  NB_INSTANCES*TIMER_BITWIDTH  FIFO head; 0 when empty
captured_valid  out  NB_INSTANCES  FIFO not empty
capture_overflow  out  NB_INSTANCES  sticky: a capture was dropped while full
alarm_out  out  NB_INSTANCES  one-cycle alarm pulse

Behaviour:
Reset:
- rst is synchronous, sampled on posedge clk.
- All outputs are 0, state is IDLE, FIFOs are empty.
- Prescale counters, edge registers and alarm_armed are 0.
- An input held high through reset release counts as a rising edge on the first cycle.

Edge detection: rising(x) = x & ~x_r, with x_r registered every cycle. Actions take effect at the same posedge.

Per-channel states: IDLE, RUN.
- IDLE: counter holds its value. start rising -> RUN, counter <= 0, prescale count <= 0, alarm_armed <= 1.
- RUN: start rising restarts as above. There is no stop; only rst returns a channel to IDLE.

Counting:
- A tick occurs when prescale count == prescale[i]; prescale count then clears, otherwise it increments.
- prescale changes take effect at the next compare.
- On each tick, counter increments modulo 2^TIMER_BITWIDTH (all-ones wraps to 0, no flag).

Alarm:
- Match condition: RUN, tick, alarm_en, alarm_armed, and counter == alarm (pre-increment value).
- On match: alarm_out <= 1 for exactly one cycle.
- Periodic: counter <= 0 instead of incrementing, and alarm_armed stays 1.
- One-shot: counter increments normally and alarm_armed <= 0 until the next start rising or alarm_en rising.

Capture:
- On capture rising while RUN, the counter register value at that posedge (pre-update) is pushed.
- captured_valid rises the following cycle; latency is 1.
- capture rising while IDLE is ignored.

FIFO:
- Pop occurs when captured_valid & captured_ready.
- Push when full: dropped, and capture_overflow <= 1, except when a pop happens the same cycle, in which case both proceed.
- Push when empty: captured shows the value 1 cycle later (no fall-through).
- captured outputs 0 when empty.

Priorities (per channel, same cycle):
- rst beats everything.
- start rising beats capture, so no push happens; the counter restarts.
- rst_capture rising beats push and pop: the FIFO is emptied, overflow clears, and the counter is unaffected.
- A match and a capture in the same cycle: both happen, and the pushed value is the matched value.

Optional Feature:
MULTI_TIMER_PRESCALE_EN
- Defined: prescaler behaves as described above.
- Undefined: the prescale port is present but ignored, every RUN cycle is a tick, and no prescale registers are synthesised.

Decomposition:
- Package timer_pkg:
  - timer_state_e enum {IDLE, RUN}
  - localparams for default widths and depth
  - function clog2-based FIFO pointer width
- Sub-module capture_fifo:
  - Parameters: width, depth.
  - Ports: push/data_in, pop, flush, dout, valid, full.
  - Instantiated once per channel inside a generate loop.
- Top-level holds the edge detectors, prescaler, counter and alarm logic.

Test Plan:
1. Reset then start[0] rising, prescale=0 -> counter[0] = 0,1,2,... each cycle; all other channels stay 0, IDLE.
2. prescale[1]=3, start[1] -> counter[1] increments every 4th cycle; after 40 cycles counter[1] = 10.
3. Periodic: alarm[2]=5, alarm_en=1, periodic=1 -> alarm_out[2] pulses every 6 ticks and counter cycles 0..5. One-shot: a single pulse, then counter continues 6,7,...
4. Capture with captured_ready=0:
   - captures at counter 7,9,11,13,15 with DEPTH=4 -> FIFO holds 7,9,11,13 and capture_overflow[3]=1.
   - pop 4 -> outputs 7,9,11,13, then captured=0, valid=0.
   - rst_capture clears overflow.
5. Same-cycle start+capture -> no push, counter 0. Push+pop while full -> both occur, no overflow. rst_capture+capture -> FIFO empty.
6. rst asserted mid-run with FIFO non-empty -> next cycle all outputs 0, state IDLE. Counter wrap with TIMER_BITWIDTH=4: 15 -> 0 with no alarm unless alarm=15.
